request_encoder32: RTL and testbench



---
 rtl/encoder_pkg.sv | 11 +
 rtl/priority_encoder32.sv | 28 ++
 rtl/request_encoder32.sv | 106 ++++++++++
 tb/tb_request_encoder32.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and sizes for the 32-line request encoder.
package encoder_pkg;

  localparam int WIDTH = 32;
  localparam int IDX_W = 5;

  typedef enum logic {IDLE, GRANT} enc_state_t;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/priority_encoder32.sv
// Combinational 32-line search: lowest set bit, or first set bit at/above start
// with wrap-around when round-robin is enabled.
module priority_encoder32
  import encoder_pkg::*;
(
  input  logic [WIDTH-1:0] vec,
  input  idx_t             start,
  input  logic             rr_en,
  output idx_t             idx,
  output logic             found
);

  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] search;

  always_comb begin
    // Bits at or above the pointer take precedence; if none, the wrap falls
    // back to the whole vector, which also gives plain lowest-index priority.
    hi_mask = rr_en ? (vec & ({WIDTH{1'b1}} << start)) : '0;
    search  = (|hi_mask) ? hi_mask : vec;
    found   = |vec;
    idx     = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (search[i]) idx = idx_t'(i);
    end
  end

endmodule

// File: rtl/request_encoder32.sv
// Sticky 32-line request collector that hands out one binary line index per
// valid/ready handshake, round-robin or fixed-priority.
module request_encoder32 #(
  parameter int WIDTH       = 32,
  parameter int IDX_W       = 5,
  parameter int ROUND_ROBIN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] req_in,
  input  logic             req_en,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [WIDTH-1:0] grant_onehot,
  output logic [WIDTH-1:0] pending
);

  import encoder_pkg::*;

  localparam logic RR_EN = (ROUND_ROBIN != 0);

  enc_state_t       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  idx_t             idx_q, idx_d;
  idx_t             ptr_q, ptr_d;

  logic             handshake;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] search_vec;
  idx_t             next_ptr;
  idx_t             search_start;
  idx_t             sel_idx;
  logic             sel_found;

  assign handshake    = (state_q == GRANT) && grant_ready;
  assign clr_mask     = handshake ? onehot_q : '0;
  // The line being accepted this edge must not be re-selected, even if it is
  // re-requested in the same cycle; it returns through pending instead.
  assign search_vec   = pending_q & ~clr_mask;
  assign next_ptr     = idx_q + idx_t'(1);
  assign search_start = handshake ? next_ptr : ptr_q;

  priority_encoder32 u_search (
    .vec   (search_vec),
    .start (search_start),
    .rr_en (RR_EN),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    onehot_d  = onehot_q;
    ptr_d     = ptr_q;
    pending_d = (pending_q & ~clr_mask) | (req_en ? req_in : '0);

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d  = GRANT;
          idx_d    = sel_idx;
          onehot_d = WIDTH'(1) << sel_idx;
        end
      end
      GRANT: begin
        if (handshake) begin
          ptr_d = next_ptr;
          if (sel_found) begin
            idx_d    = sel_idx;
            onehot_d = WIDTH'(1) << sel_idx;
          end else begin
            state_d  = IDLE;
            onehot_d = '0;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      onehot_q  <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_request_encoder32.sv
// Self-checking bench: round-robin and fixed-priority instances driven in
// parallel and compared every cycle against a behavioural model.
module tb_request_encoder32;

  typedef struct packed {
    logic [31:0] pend;
    logic        valid;
    logic [4:0]  idx;
    logic [4:0]  ptr;
  } model_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] req_in = '0;
  logic        req_en = 1'b0;
  logic        grant_ready = 1'b0;

  logic        rr_valid, fp_valid;
  logic [4:0]  rr_idx, fp_idx;
  logic [31:0] rr_oh, fp_oh, rr_pend, fp_pend;

  model_t m_rr = '0;
  model_t m_fp = '0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  request_encoder32 #(.WIDTH(32), .IDX_W(5), .ROUND_ROBIN(1)) u_dut_rr (
    .clk(clk), .reset_n(reset_n), .req_in(req_in), .req_en(req_en),
    .grant_ready(grant_ready), .grant_valid(rr_valid), .grant_idx(rr_idx),
    .grant_onehot(rr_oh), .pending(rr_pend)
  );

  request_encoder32 #(.WIDTH(32), .IDX_W(5), .ROUND_ROBIN(0)) u_dut_fp (
    .clk(clk), .reset_n(reset_n), .req_in(req_in), .req_en(req_en),
    .grant_ready(grant_ready), .grant_valid(fp_valid), .grant_idx(fp_idx),
    .grant_onehot(fp_oh), .pending(fp_pend)
  );

  wire [69:0] rr_obs = {rr_valid, rr_idx, rr_oh, rr_pend};
  wire [69:0] fp_obs = {fp_valid, fp_idx, fp_oh, fp_pend};

  // Walk the 32 lines in search order and return the first pending one.
  function automatic bit find_next(input logic [31:0] vec, input int start,
                                   input bit rr, output int idx);
    int pos;
    idx = 0;
    for (int k = 0; k < 32; k++) begin
      pos = rr ? (start + k) % 32 : k;
      if (vec[pos]) begin
        idx = pos;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic model_t model_next(input model_t m, input bit rr);
    model_t      n;
    logic [31:0] clr;
    bit          hs;
    int          sel;
    int          start;
    n     = m;
    hs    = m.valid && grant_ready;
    clr   = hs ? (32'd1 << m.idx) : 32'd0;
    start = hs ? (int'(m.idx) + 1) % 32 : int'(m.ptr);
    if (hs) n.ptr = 5'((int'(m.idx) + 1) % 32);
    if (!m.valid || hs) begin
      if (find_next(m.pend & ~clr, start, rr, sel)) begin
        n.valid = 1'b1;
        n.idx   = 5'(sel);
      end else begin
        n.valid = 1'b0;
      end
    end
    n.pend = (m.pend & ~clr) | (req_en ? req_in : 32'd0);
    return n;
  endfunction

  function automatic logic [69:0] expect_of(input model_t m);
    return {m.valid, m.idx, (m.valid ? (32'd1 << m.idx) : 32'd0), m.pend};
  endfunction

  // Advance one clock edge and move both models with it; returns 1 ns after the edge.
  task automatic tick();
    model_t nr, nf;
    nr = reset_n ? model_next(m_rr, 1'b1) : '0;
    nf = reset_n ? model_next(m_fp, 1'b0) : '0;
    @(posedge clk);
    m_rr = nr;
    m_fp = nf;
    #1;
  endtask

  task automatic do_reset();
    #3 reset_n = 1'b0;
    m_rr = '0;
    m_fp = '0;
    req_en = 1'b0;
    req_in = '0;
    tick();
    #2 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    grant_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_en = 1'b1;
      req_in = $urandom | 32'h0000_0100;
      tick();
      n_checks++;
      if (rr_obs !== expect_of(m_rr)) begin
        n_fail++;
        $display("FAIL reset_fill rr: got %h want %h", rr_obs, expect_of(m_rr));
      end
    end
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (rr_obs !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_async rr: got %h want 0", rr_obs);
    end
    n_checks++;
    if (fp_obs !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_async fp: got %h want 0", fp_obs);
    end
    m_rr = '0;
    m_fp = '0;
    req_en = 1'b0;
    req_in = '0;
    tick();
    #2 reset_n = 1'b1;
    tick();
    n_checks++;
    if (rr_obs !== expect_of(m_rr) || fp_obs !== expect_of(m_fp)) begin
      n_fail++;
      $display("FAIL reset_release: got rr %h fp %h want %h", rr_obs, fp_obs, expect_of(m_rr));
    end
  endtask

  task automatic test_single();
    grant_ready = 1'b1;
    req_en = 1'b1;
    req_in = 32'h0000_0020;
    tick();
    req_en = 1'b0;
    req_in = '0;
    n_checks++;
    if (rr_pend !== 32'h20 || rr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pend: got pend %h valid %b want 20 0", rr_pend, rr_valid);
    end
    tick();
    n_checks++;
    if (rr_valid !== 1'b1 || rr_idx !== 5'd5 || rr_oh !== 32'h20) begin
      n_fail++;
      $display("FAIL single_grant: got %b %0d %h want 1 5 20", rr_valid, rr_idx, rr_oh);
    end
    n_checks++;
    if (fp_obs !== expect_of(m_fp)) begin
      n_fail++;
      $display("FAIL single_grant fp: got %h want %h", fp_obs, expect_of(m_fp));
    end
    tick();
    n_checks++;
    if (rr_valid !== 1'b0 || rr_pend !== 32'h0 || rr_oh !== 32'h0 || rr_idx !== 5'd5) begin
      n_fail++;
      $display("FAIL single_after: got %b %0d %h %h want 0 5 0 0", rr_valid, rr_idx, rr_oh, rr_pend);
    end
  endtask

  task automatic test_enable_gating();
    req_en = 1'b0;
    req_in = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (rr_pend !== 32'h0 || rr_valid !== 1'b0 || fp_pend !== 32'h0 || fp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL gating: got rr %h/%b fp %h/%b want 0/0", rr_pend, rr_valid, fp_pend, fp_valid);
      end
    end
    req_in = '0;
  endtask

  task automatic test_rr_wrap();
    int exp_a[3] = '{0, 4, 31};
    int exp_b[2] = '{0, 31};
    int exp_c[2] = '{31, 0};
    do_reset();
    grant_ready = 1'b1;
    req_en = 1'b1;
    req_in = 32'h8000_0011;
    tick();
    req_en = 1'b0;
    req_in = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (rr_valid !== 1'b1 || rr_idx !== 5'(exp_a[i]) || rr_obs !== expect_of(m_rr)) begin
        n_fail++;
        $display("FAIL rr_wrap_a[%0d]: got %b %0d want 1 %0d", i, rr_valid, rr_idx, exp_a[i]);
      end
    end
    tick();
    // Pointer is back at 0 after granting 31, so 0 must precede 31 here.
    req_en = 1'b1;
    req_in = 32'h8000_0001;
    tick();
    req_en = 1'b0;
    req_in = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (rr_valid !== 1'b1 || rr_idx !== 5'(exp_b[i])) begin
        n_fail++;
        $display("FAIL rr_wrap_b[%0d]: got %b %0d want 1 %0d", i, rr_valid, rr_idx, exp_b[i]);
      end
    end
    do_reset();
    req_en = 1'b1;
    req_in = 32'h0000_0010;
    tick();
    req_in = 32'h0;
    req_en = 1'b0;
    tick();
    req_en = 1'b1;
    req_in = 32'h8000_0001;
    tick();
    req_en = 1'b0;
    req_in = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (rr_valid !== 1'b1 || rr_idx !== 5'(exp_c[i]) || rr_obs !== expect_of(m_rr)) begin
        n_fail++;
        $display("FAIL rr_wrap_c[%0d]: got %b %0d want 1 %0d", i, rr_valid, rr_idx, exp_c[i]);
      end
      n_checks++;
      if (fp_obs !== expect_of(m_fp)) begin
        n_fail++;
        $display("FAIL rr_wrap_c fp[%0d]: got %h want %h", i, fp_obs, expect_of(m_fp));
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    grant_ready = 1'b0;
    req_en = 1'b1;
    req_in = 32'h0000_0080;
    tick();
    req_en = 1'b0;
    req_in = '0;
    tick();
    for (int c = 0; c < 10; c++) begin
      req_en = (c == 3);
      req_in = (c == 3) ? 32'h1 : 32'h0;
      tick();
      n_checks++;
      if (rr_valid !== 1'b1 || rr_idx !== 5'd7 || rr_oh !== 32'h80 || fp_obs !== expect_of(m_fp)) begin
        n_fail++;
        $display("FAIL hold[%0d]: got rr %b %0d %h want 1 7 80", c, rr_valid, rr_idx, rr_oh);
      end
    end
    grant_ready = 1'b1;
    req_en = 1'b1;
    req_in = 32'h0000_0080;
    tick();
    req_en = 1'b0;
    req_in = '0;
    n_checks++;
    if (rr_valid !== 1'b1 || rr_idx !== 5'd0 || rr_pend[7] !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_next: got %b %0d pend %h want 1 0 bit7", rr_valid, rr_idx, rr_pend);
    end
    tick();
    n_checks++;
    if (rr_valid !== 1'b1 || rr_idx !== 5'd7 || rr_obs !== expect_of(m_rr)) begin
      n_fail++;
      $display("FAIL collide_regrant: got %b %0d want 1 7", rr_valid, rr_idx);
    end
    tick();
    n_checks++;
    if (rr_valid !== 1'b0 || rr_pend !== 32'h0 || fp_obs !== expect_of(m_fp)) begin
      n_fail++;
      $display("FAIL collide_drain: got %b %h want 0 0", rr_valid, rr_pend);
    end
  endtask

  task automatic test_fixed_priority();
    int zero_grants = 0;
    bit seen;
    do_reset();
    grant_ready = 1'b1;
    req_en = 1'b1;
    req_in = 32'h0000_0011;
    tick();
    req_in = 32'h0000_0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (fp_valid === 1'b1 && fp_idx === 5'd0) zero_grants++;
      n_checks++;
      if (fp_obs !== expect_of(m_fp)) begin
        n_fail++;
        $display("FAIL fixed[%0d]: got %h want %h", c, fp_obs, expect_of(m_fp));
      end
    end
    n_checks++;
    if (zero_grants != 4) begin
      n_fail++;
      $display("FAIL fixed_repeat: got %0d grants of 0 want 4", zero_grants);
    end
    grant_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      tick();
      seen = (fp_valid === 1'b1);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL fixed_wait_grant: got no grant within 4 cycles want grant");
    end
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if (fp_obs !== 70'd0 || rr_obs !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_in_grant: got fp %h rr %h want 0", fp_obs, rr_obs);
    end
    m_rr = '0;
    m_fp = '0;
    req_en = 1'b0;
    req_in = '0;
    tick();
    #2 reset_n = 1'b1;
    grant_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (fp_valid !== 1'b0 || fp_pend !== 32'h0 || rr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL no_replay[%0d]: got fp %b rr %b want 0", c, fp_valid, rr_valid);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_in = $urandom & $urandom & $urandom;
      req_en = 1'($urandom_range(0, 1));
      grant_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (rr_obs !== expect_of(m_rr)) begin
        n_fail++;
        $display("FAIL random rr[%0d]: got %h want %h", c, rr_obs, expect_of(m_rr));
      end
      n_checks++;
      if (fp_obs !== expect_of(m_fp)) begin
        n_fail++;
        $display("FAIL random fp[%0d]: got %h want %h", c, fp_obs, expect_of(m_fp));
      end
    end
  endtask

  initial begin
    tick();
    tick();
    #2 reset_n = 1'b1;
    test_reset();
    test_single();
    test_enable_gating();
    test_rr_wrap();
    test_backpressure();
    test_fixed_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
